alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//   Parametrised, handshaked successor to the single-width ALU. Accepts one operation per
//   valid/ready transfer and produces a registered result with status flags. Adds an
//   iterative shift-add multiply. The output holds under downstream backpressure. Sits
//   between the operand issue logic and the result consumer in the datapath.
// PARAMETERS
//   WIDTH   8  operand/result width in bits; power of two, >= 4
//   MUL_EN  1  1: op MUL implemented; 0: op MUL treated as illegal, no multiplier logic
// PORTS
//   clk          in   1      clock; all state updates on rising edge
//   rst          in   1      synchronous, active-high reset
//   in_valid_i   in   1      operation request valid
//   in_ready_o   out  1      block can accept an operation this cycle
//   a_i          in   WIDTH  operand A
//   b_i          in   WIDTH  operand B; low $clog2(WIDTH) bits are the shift amount for shifts
//   op_i         in   4      opcode, see BEHAVIOUR
//   out_valid_o  out  1      result register holds an unconsumed result
//   out_ready_i  in   1      consumer accepts the result this cycle
//   result_o     out  WIDTH  result
//   zero_o       out  1      result_o == 0 (legal ops only)
//   carry_o      out  1      carry/borrow/shift-out/MUL high-half-nonzero
//   overflow_o   out  1      signed overflow, ADD/SUB only
//   error_o      out  1      illegal opcode
//   busy_o       out  1      multiply in progress
// BEHAVIOUR
//   Reset: state=IDLE; out_valid_o, result_o, zero_o, carry_o, overflow_o, error_o, busy_o all 0.
//     in_ready_o=0 while rst=1. A reset asserted mid-multiply aborts it and produces no result.
//   Handshake: input transfer on edge with in_valid_i & in_ready_o; output transfer on edge
//     with out_valid_o & out_ready_i.
//   in_ready_o = !rst & (state==IDLE) & (!out_valid_o | out_ready_i). This is a combinational path
//     from out_ready_i, so back-to-back throughput is 1 op/cycle for single-cycle ops.
//   Output register: result and flags stay stable while out_valid_o & !out_ready_i.
//     out_valid_o clears on the consuming edge unless a new result loads on the same edge.
//   Opcodes (C = carry_o, V = overflow_o):
//     0 ADD: {C,result} = a+b; V = signed overflow
//     1 SUB: result = a-b; C = borrow (a<b unsigned); V = signed overflow
//     2 AND, 3 OR, 4 XOR: C = 0, V = 0
//     5 SHL, 6 SHR (logical), 7 SRA (arithmetic): shamt = b[$clog2(WIDTH)-1:0]
//       C = last bit shifted out; C = 0 if shamt == 0
//     8 MUL: unsigned; result = low WIDTH bits of product; C = |high WIDTH bits
//     9..15, or 8 with MUL_EN=0: illegal; result 0, error 1, zero/carry/overflow 0
//   Latency, single-cycle ops: accept on edge N; results visible with out_valid_o=1 after edge N.
//   FSM: IDLE -> MUL on acceptance of a legal MUL; MUL -> IDLE after WIDTH iterations.
//     The last iteration loads the output register and sets out_valid_o.
//     MUL: busy_o=1, in_ready_o=0.
//   MUL datapath: shift-add; 2*WIDTH accumulator; iteration counter counts WIDTH..1.
//     Accept on edge N; out_valid_o rises after edge N+WIDTH.
//     Operands are captured at acceptance; later changes to a_i/b_i are ignored.
//   Entering MUL requires the output register to be free, so a MUL result never overwrites
//     an unconsumed result.
// TESTING (WIDTH=8 unless noted)
//   ADD F0+20 -> result 10, carry 1, overflow 0, zero 0; out_valid_o 1 cycle after accept.
//   SUB 80-01 -> 7F, carry 0, overflow 1. SUB 05-05 -> 00, zero 1.
//   Back-to-back ops with out_ready_i=1 -> one result per cycle, in order.
//   MUL 10*11 -> result 10, carry 1; out_valid_o 8 edges after accept.
//     busy_o=1 and in_ready_o=0 throughout.
//   out_ready_i=0 for 5 cycles with a result pending -> outputs stable, in_ready_o=0.
//     A new ADD is accepted on the edge out_ready_i returns to 1.
//   op C -> error 1, result 00. MUL_EN=0 with op 8 -> error 1.
//     rst pulsed on 3rd MUL cycle -> no out_valid_o, busy_o=0 next cycle, following ADD correct.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with a registered result and status flags.
//   Single-cycle ops (ADD/SUB/logic/shifts) load the output register on the
//   accepting edge. MUL is an iterative shift-add unit taking WIDTH cycles.
//   The output register holds its contents while the consumer stalls.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid_i / in_ready_o   request handshake (a_i, b_i, op_i)
//   out_valid_o / out_ready_i result handshake (result_o and flags)
//   zero_o, carry_o, overflow_o, error_o   status of the held result
//   busy_o                    multiply in progress
module alu_pipe #(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             error_o,
  output logic             busy_o
);
  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t               state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 carry_q, carry_d;
  logic                 ovf_q, ovf_d;
  logic                 err_q, err_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 accept;
  logic                 op_mul;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c, alu_v, alu_err;
  logic [WIDTH:0]       wide;
  logic [SH_W-1:0]      shamt;
  logic [2*WIDTH-1:0]   acc_sum;
  logic                 mul_last;

  // Combinational from out_ready_i: a result being consumed frees the register.
  assign in_ready_o = !rst && (state_q == S_IDLE) && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign op_mul     = (op_i == 4'd8) && (MUL_EN != 0);
  assign shamt      = b_i[SH_W-1:0];

  // Single-cycle ALU. Shifts use a WIDTH+1 vector so the last bit shifted out
  // lands in the spare bit; a zero shift leaves that bit at 0.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    wide    = '0;
    case (op_i)
      4'd0: begin
        wide    = {1'b0, a_i} + {1'b0, b_i};
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
        alu_v   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (wide[WIDTH-1] != a_i[WIDTH-1]);
      end
      4'd1: begin
        wide    = {1'b0, a_i} - {1'b0, b_i};
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
        alu_v   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (wide[WIDTH-1] != a_i[WIDTH-1]);
      end
      4'd2: alu_res = a_i & b_i;
      4'd3: alu_res = a_i | b_i;
      4'd4: alu_res = a_i ^ b_i;
      4'd5: begin
        wide    = {1'b0, a_i} << shamt;
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
      end
      4'd6: begin
        wide    = {a_i, 1'b0} >> shamt;
        alu_res = wide[WIDTH:1];
        alu_c   = wide[0];
      end
      4'd7: begin
        wide    = $unsigned($signed({a_i, 1'b0}) >>> shamt);
        alu_res = wide[WIDTH:1];
        alu_c   = wide[0];
      end
      // Opcode 8 lands here too; when MUL is enabled this path is never loaded.
      default: alu_err = 1'b1;
    endcase
  end

  assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last = (state_q == S_MUL) && (cnt_q == CNT_W'(1));

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;

    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept && op_mul) begin
          state_d  = S_MUL;
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, a_i};
          mplier_d = b_i;
          cnt_d    = CNT_W'(WIDTH);
        end else if (accept) begin
          out_valid_d = 1'b1;
          result_d    = alu_res;
          zero_d      = !alu_err && (alu_res == '0);
          carry_d     = alu_c;
          ovf_d       = alu_v;
          err_d       = alu_err;
        end
      end
      S_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (mul_last) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b1;
          result_d    = acc_sum[WIDTH-1:0];
          zero_d      = (acc_sum[WIDTH-1:0] == '0);
          carry_d     = |acc_sum[2*WIDTH-1:WIDTH];
          ovf_d       = 1'b0;
          err_d       = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign zero_o      = zero_q;
  assign carry_o     = carry_q;
  assign overflow_o  = ovf_q;
  assign error_o     = err_q;
  assign busy_o      = (state_q == S_MUL);

endmodule
